// File: rtl/seq_param_comparator.sv
// Sequential magnitude comparator: walks the operands CHUNK bits per cycle,
// MSB chunk first, and stops at the first chunk that differs.
module seq_param_comparator #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             Equal,
    output logic             Greater,
    output logic             Less
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               equal_q, equal_d;
    logic               greater_q, greater_d;
    logic               less_q, less_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   a_shift, b_shift;
    logic [CHUNK-1:0]   a_chunk, b_chunk;

    // Shifting rather than indexing keeps the select in range for any idx value.
    assign a_shift = a_q >> (CHUNK * idx_q);
    assign b_shift = b_q >> (CHUNK * idx_q);
    assign a_chunk = a_shift[CHUNK-1:0];
    assign b_chunk = b_shift[CHUNK-1:0];

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path leaves a signal unassigned (no latches).
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        equal_d   = equal_q;
        greater_d = greater_q;
        less_d    = less_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Offset binary: flipping both MSBs turns a signed compare into an unsigned one.
                    a_d       = A ^ (Signed ? MSB_MASK : '0);
                    b_d       = B ^ (Signed ? MSB_MASK : '0);
                    idx_d     = IDX_W'(NUM_CHUNKS - 1);
                    equal_d   = 1'b0;
                    greater_d = 1'b0;
                    less_d    = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (a_chunk != b_chunk) begin
                    greater_d = (a_chunk > b_chunk);
                    less_d    = (a_chunk < b_chunk);
                    state_d   = DONE;
                end else if (idx_q == '0) begin
                    equal_d = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            equal_q   <= 1'b0;
            greater_q <= 1'b0;
            less_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            equal_q   <= equal_d;
            greater_q <= greater_d;
            less_q    <= less_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign Equal   = equal_q;
    assign Greater = greater_q;
    assign Less    = less_q;

endmodule

// File: tb/tb_seq_param_comparator.sv
// Bench for seq_param_comparator: directed scenarios plus randomized compares
// on an 8-bit/2-bit-chunk instance and a 16-bit single-chunk instance.
module tb_seq_param_comparator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start8, sgn8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, eq8, gt8, lt8;

    logic        start16, sgn16;
    logic [15:0] a16, b16;
    logic        busy16, done16, eq16, gt16, lt16;

    int n_cmp = 0;
    int n_err = 0;

    bit          sel16 = 1'b0;
    logic        busy_m, done_m;
    logic [2:0]  flags_m;
    assign busy_m  = sel16 ? busy16 : busy8;
    assign done_m  = sel16 ? done16 : done8;
    assign flags_m = sel16 ? {eq16, gt16, lt16} : {eq8, gt8, lt8};

    seq_param_comparator #(.WIDTH(8), .CHUNK(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .Signed(sgn8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .Equal(eq8), .Greater(gt8), .Less(lt8)
    );

    seq_param_comparator #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .Signed(sgn16), .A(a16), .B(b16),
        .busy(busy16), .done(done16), .Equal(eq16), .Greater(gt16), .Less(lt16)
    );

    // Everything observed over one compare; flags are ordered {eq, gt, lt}.
    typedef struct packed {
        logic [7:0] lat;
        logic [7:0] busy_cnt;
        logic [2:0] clr;
        logic [2:0] flags;
        logic       busy_at_done;
        logic [2:0] hold;
        logic       done_after;
    } obs_t;

    function automatic obs_t make_exp(input int lat, input logic [2:0] flags);
        obs_t e;
        e              = '0;
        e.lat          = 8'(lat);
        e.busy_cnt     = 8'(lat);
        e.flags        = flags;
        e.hold         = flags;
        return e;
    endfunction

    // Reference: integer value compare, latency from the most significant differing chunk.
    function automatic obs_t model(input logic [15:0] a, input logic [15:0] b,
                                   input bit s, input int w, input int chunk);
        int         va, vb, lat, nch;
        bit         found;
        logic [2:0] f;
        nch   = w / chunk;
        va    = (s && a[w-1]) ? int'(a) - (1 << w) : int'(a);
        vb    = (s && b[w-1]) ? int'(b) - (1 << w) : int'(b);
        lat   = nch;
        found = 1'b0;
        for (int k = nch - 1; k >= 0; k--) begin
            if (!found && ((int'(a ^ b) >> (k * chunk)) & ((1 << chunk) - 1)) != 0) begin
                lat   = nch - k;
                found = 1'b1;
            end
        end
        f = (va == vb) ? 3'b100 : (va > vb) ? 3'b010 : 3'b001;
        return make_exp(lat, f);
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("lat=%0d busy_cyc=%0d clr=%b flags(eq,gt,lt)=%b busy@done=%b hold=%b done_after=%b",
                         o.lat, o.busy_cnt, o.clr, o.flags, o.busy_at_done, o.hold, o.done_after);
    endfunction

    // Called right after a negedge; returns right after a negedge in the IDLE cycle after DONE.
    task automatic run(input bit use16, input logic [15:0] a, input logic [15:0] b,
                       input bit s, input bit disturb, output obs_t o);
        int k;
        bit got;
        o     = '0;
        sel16 = use16;
        if (use16) begin
            start16 = 1'b1; a16 = a; b16 = b; sgn16 = s;
        end else begin
            start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; sgn8 = s;
        end
        @(posedge clk);
        @(negedge clk);
        start8  = 1'b0;
        start16 = 1'b0;
        o.clr   = flags_m;
        if (disturb) begin
            if (use16) begin
                start16 = 1'b1; a16 = b; b16 = a; sgn16 = ~s;
            end else begin
                start8 = 1'b1; a8 = b[7:0]; b8 = a[7:0]; sgn8 = ~s;
            end
        end
        k   = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            if (done_m) begin
                got            = 1'b1;
                o.lat          = 8'(k);
                o.flags        = flags_m;
                o.busy_at_done = busy_m;
            end else begin
                if (busy_m) o.busy_cnt = o.busy_cnt + 8'd1;
                k++;
                @(negedge clk);
            end
        end
        start8  = 1'b0;
        start16 = 1'b0;
        @(negedge clk);
        o.hold       = flags_m;
        o.done_after = done_m;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy8, done8, eq8, gt8, lt8} !== 5'b0) begin
            n_err++;
            $display("FAIL reset8: got busy,done,eq,gt,lt=%b want 00000", {busy8, done8, eq8, gt8, lt8});
        end
        n_cmp++;
        if ({busy16, done16, eq16, gt16, lt16} !== 5'b0) begin
            n_err++;
            $display("FAIL reset16: got busy,done,eq,gt,lt=%b want 00000", {busy16, done16, eq16, gt16, lt16});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_equal;
        obs_t o, e;
        run(1'b0, 16'hA5, 16'hA5, 1'b0, 1'b0, o);
        e = make_exp(4, 3'b100);
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL v1_equal: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_msb_chunk;
        obs_t o, e;
        run(1'b0, 16'h80, 16'h7F, 1'b0, 1'b0, o);
        e = make_exp(1, 3'b010);
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL v2_unsigned: got %s want %s", fmt(o), fmt(e));
        end
        run(1'b0, 16'h80, 16'h7F, 1'b1, 1'b0, o);
        e = make_exp(1, 3'b001);
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL v2_signed: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_inner_chunks;
        obs_t o, e;
        run(1'b0, 16'h34, 16'h24, 1'b0, 1'b0, o);
        e = make_exp(2, 3'b010);
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL v3_chunk2: got %s want %s", fmt(o), fmt(e));
        end
        run(1'b0, 16'h12, 16'h13, 1'b0, 1'b0, o);
        e = make_exp(4, 3'b001);
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL v3_lsb_chunk: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_ignore_and_hold;
        obs_t o, e;
        run(1'b0, 16'hFF, 16'h00, 1'b1, 1'b1, o);
        e = make_exp(1, 3'b001);
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL v4_ignore_start: got %s want %s", fmt(o), fmt(e));
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy8, done8, eq8, gt8, lt8} !== 5'b00001) begin
                n_err++;
                $display("FAIL v4_hold[%0d]: got busy,done,eq,gt,lt=%b want 00001", i, {busy8, done8, eq8, gt8, lt8});
            end
        end
    endtask

    task automatic test_reset_abort;
        obs_t o, e;
        bit   saw_done;
        sel16 = 1'b0;
        start8 = 1'b1; a8 = 8'hA5; b8 = 8'hA5; sgn8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy8, done8, eq8, gt8, lt8} !== 5'b0) begin
            n_err++;
            $display("FAIL v5_async_reset: got busy,done,eq,gt,lt=%b want 00000", {busy8, done8, eq8, gt8, lt8});
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_done |= done8;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            saw_done |= done8;
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_err++;
            $display("FAIL v5_no_done: got done pulse=%b want 0", saw_done);
        end
        run(1'b0, 16'h01, 16'h02, 1'b0, 1'b0, o);
        e = make_exp(4, 3'b001);
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL v5_restart: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_back_to_back;
        obs_t o, e;
        run(1'b1, 16'h8000, 16'h7FFF, 1'b1, 1'b0, o);
        e = make_exp(1, 3'b001);
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL v6_signed16: got %s want %s", fmt(o), fmt(e));
        end
        run(1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b0, o);
        e = make_exp(1, 3'b010);
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL v6_b2b_unsigned16: got %s want %s", fmt(o), fmt(e));
        end
        run(1'b1, 16'h1234, 16'h1234, 1'b0, 1'b0, o);
        e = make_exp(1, 3'b100);
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL v6_b2b_equal16: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_random;
        obs_t        o, e;
        logic [15:0] a, b;
        bit          s;
        for (int i = 0; i < 60; i++) begin
            bit use16;
            int w;
            use16 = (i >= 45);
            w     = use16 ? 16 : 8;
            a     = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       b = a;
                1:       b = a ^ (16'd1 << $urandom_range(0, w - 1));
                default: b = 16'($urandom);
            endcase
            if (!use16) begin
                a = a & 16'h00FF;
                b = b & 16'h00FF;
            end
            s = 1'($urandom);
            e = model(a, b, s, w, use16 ? 16 : 2);
            run(use16, a, b, s, 1'b0, o);
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL rand[%0d] w=%0d a=%h b=%h s=%b: got %s want %s", i, w, a, b, s, fmt(o), fmt(e));
            end
        end
    endtask

    initial begin
        test_reset;
        test_equal;
        test_msb_chunk;
        test_inner_chunks;
        test_ignore_and_hold;
        test_reset_abort;
        test_back_to_back;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_param_comparator.md
SEQ_PARAM_COMPARATOR -- requirements
Module: seq_param_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 2, giving the bits compared per cycle; WIDTH mod CHUNK = 0 and 1 <= CHUNK <= WIDTH are required.
REQ-003 The block SHALL derive NUM_CHUNKS = WIDTH/CHUNK internally.
REQ-004 The block SHALL have the following ports:
- clk  input  1  -- single clock; all state updates on its rising edge.
- rst_n  input  1  -- reset; asynchronous, active-low.
- start  input  1  -- request a compare; sampled only in IDLE.
- Signed  input  1  -- 1 = two's-complement compare, 0 = unsigned; captured with start.
- A  input  WIDTH  -- operand A; captured with start.
- B  input  WIDTH  -- operand B; captured with start.
- busy  output  1  -- high while a compare is in progress (RUN).
- done  output  1  -- one-cycle pulse; result flags valid.
- Equal  output  1  -- registered result A == B.
- Greater  output  1  -- registered result A > B.
- Less  output  1  -- registered result A < B.

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-006 In IDLE with start=1 at a clock edge (T0), the block SHALL:
- capture A, B and Signed into internal registers;
- clear Equal, Greater and Less to 0;
- load the chunk index with NUM_CHUNKS-1;
- enter RUN.
REQ-007 In Signed mode, the captured operands SHALL have their MSB inverted at capture (offset binary), so that all later chunk compares are unsigned.
REQ-008 Each edge in RUN SHALL compare captured chunk [idx*CHUNK +: CHUNK] of A against the same chunk of B, MSB chunk first.
REQ-009 If the chunks differ, the block SHALL set Greater=1 (A chunk > B chunk) or Less=1 (otherwise) and enter DONE (early exit).
REQ-010 If the chunks are equal and idx=0, the block SHALL set Equal=1 and enter DONE.
REQ-011 If the chunks are equal and idx>0, the block SHALL decrement idx and stay in RUN.
REQ-012 Latency: a result decided at compare n (1..NUM_CHUNKS) SHALL register at edge T0+n, with done=1 for the cycle after edge T0+n.
REQ-013 Minimum latency SHALL be 1 (MSB chunk differs, or CHUNK=WIDTH); maximum latency SHALL be NUM_CHUNKS (equal operands, or only the LSB chunk differs).
REQ-014 DONE SHALL last exactly one cycle, with done=1 and busy=0, then return to IDLE.
REQ-015 busy SHALL be 1 exactly while in RUN.
REQ-016 start SHALL be ignored in RUN and DONE; operand or Signed changes after T0 SHALL NOT affect the result in progress.
REQ-017 Whenever done=1, exactly one of Equal, Greater and Less SHALL be 1.
REQ-018 The flags SHALL hold their value after DONE until the next accepted start clears them.
REQ-019 A start in IDLE on the cycle immediately after DONE SHALL be accepted normally (back-to-back).

Reset
REQ-020 On rst_n=0 the block SHALL asynchronously:
- enter IDLE;
- force busy, done, Equal, Greater and Less to 0;
- clear the captured operands, Signed and idx to 0.
REQ-021 A reset asserted during RUN or DONE SHALL abort the operation with no done pulse; the first accepted start after rst_n deasserts SHALL behave as in REQ-006.

Verification (WIDTH=8, CHUNK=2 unless stated)
REQ-022 The bench SHALL cover the following directed scenarios:
- V1: A=8'hA5, B=8'hA5, Signed=0, start pulse -> busy for 4 cycles; done after edge T0+4; Equal=1, Greater=0, Less=0.
- V2: A=8'h80, B=8'h7F, Signed=0 -> done after edge T0+1, Greater=1; repeat with Signed=1 -> done after edge T0+1, Less=1.
- V3: A=8'h34, B=8'h24, Signed=0 -> differs at the 2nd chunk; done after edge T0+2, Greater=1. A=8'h12, B=8'h13 -> done after edge T0+4, Less=1.
- V4: start with A=8'hFF, B=8'h00, Signed=1; during RUN drive start=1, A=8'h00, B=8'hFF -> second start ignored; result Less=1 (-1 < 0); flags held for 5 idle cycles after done.
- V5: rst_n pulsed low at T0+1 of a V1 compare -> all outputs 0 immediately; no done; a new start (A=8'h01, B=8'h02) -> Less=1 after edge T0+4.
- V6: WIDTH=16, CHUNK=16, A=16'h8000, B=16'h7FFF, Signed=1 -> done after edge T0+1, Less=1; back-to-back start on the cycle after DONE is accepted.
